// File: rtl/multi_cycle_control.sv
// Multi-cycle control unit for the MIPS-subset datapath: walks each instruction through
// IF/ID/EXE/MEM/WB, drives datapath strobes per state, traps illegal opcodes and counts retirements.
module multi_cycle_control #(
    parameter int OP_W     = 6,
    parameter int FUNC_W   = 6,
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 32
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [OP_W-1:0]   OP,
    input  logic [FUNC_W-1:0] func,
    input  logic              zero,
    input  logic              sign,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    output logic              PCWre,
    output logic              IRWre,
    output logic              InsMemRW,
    output logic              ALUSrcA,
    output logic              ALUSrcB,
    output logic              DBDataSrc,
    output logic              WrRegDSrc,
    output logic              RegWre,
    output logic [1:0]        RegDst,
    output logic              ExtSel,
    output logic              mRD,
    output logic              mWR,
    output logic [2:0]        ALUOp,
    output logic [1:0]        PCSrc,
    output logic [3:0]        state,
    output logic              illegal_op,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_BLTZ  = OP_W'(6'b000001);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
    localparam logic [OP_W-1:0] OP_ADDIU = OP_W'(6'b001001);
    localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
    localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_HALT  = OP_W'(6'b111111);

    localparam logic [FUNC_W-1:0] FN_SLL = FUNC_W'(6'b000000);
    localparam logic [FUNC_W-1:0] FN_JR  = FUNC_W'(6'b001000);
    localparam logic [FUNC_W-1:0] FN_ADD = FUNC_W'(6'b100000);
    localparam logic [FUNC_W-1:0] FN_SUB = FUNC_W'(6'b100010);
    localparam logic [FUNC_W-1:0] FN_AND = FUNC_W'(6'b100100);
    localparam logic [FUNC_W-1:0] FN_OR  = FUNC_W'(6'b100101);
    localparam logic [FUNC_W-1:0] FN_SLT = FUNC_W'(6'b101010);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_SLL = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] DST_RA = 2'b00;
    localparam logic [1:0] DST_RT = 2'b01;
    localparam logic [1:0] DST_RD = 2'b10;

    localparam bit WAIT_EN = (MEM_WAIT != 0);

    typedef enum logic [3:0] {
        ST_IF     = 4'd0,
        ST_ID     = 4'd1,
        ST_EXE_AL = 4'd2,
        ST_WB_AL  = 4'd3,
        ST_EXE_BR = 4'd4,
        ST_EXE_LS = 4'd5,
        ST_MEM    = 4'd6,
        ST_WB_LD  = 4'd7,
        ST_HALT   = 4'd8
    } stateT;

    typedef enum logic [3:0] {
        K_ALU, K_BRANCH, K_LOAD, K_STORE, K_J, K_JAL, K_JR, K_HALT, K_ILLEGAL
    } kindT;

    stateT      stateReg;
    stateT      nextState;
    kindT       kind;
    logic [2:0] aluOp;
    logic       useShamt;
    logic       useImm;
    logic       zeroExt;
    logic       brTaken;
    logic       rType;
    logic       imemOk;
    logic       dmemOk;

    // With wait states disabled the memories are assumed to answer in a single cycle.
    assign imemOk = !WAIT_EN || imem_ready;
    assign dmemOk = !WAIT_EN || dmem_ready;
    assign rType  = (OP == OP_RTYPE);
    assign state  = stateReg;

    // Instruction decode; IR is stable from ID until the next IF so this holds across states.
    always_comb begin
        kind     = K_ILLEGAL;
        aluOp    = ALU_ADD;
        useShamt = 1'b0;
        useImm   = 1'b0;
        zeroExt  = 1'b0;
        brTaken  = 1'b0;
        if (rType) begin
            kind = K_ALU;
            case (func)
                FN_ADD: aluOp = ALU_ADD;
                FN_SUB: aluOp = ALU_SUB;
                FN_AND: aluOp = ALU_AND;
                FN_OR:  aluOp = ALU_OR;
                FN_SLT: aluOp = ALU_SLT;
                FN_SLL: begin
                    aluOp    = ALU_SLL;
                    useShamt = 1'b1;
                end
                FN_JR:   kind = K_JR;
                default: kind = K_ILLEGAL;
            endcase
        end else begin
            case (OP)
                OP_ADDIU: begin
                    kind   = K_ALU;
                    useImm = 1'b1;
                    aluOp  = ALU_ADD;
                end
                OP_ANDI: begin
                    kind    = K_ALU;
                    useImm  = 1'b1;
                    zeroExt = 1'b1;
                    aluOp   = ALU_AND;
                end
                OP_ORI: begin
                    kind    = K_ALU;
                    useImm  = 1'b1;
                    zeroExt = 1'b1;
                    aluOp   = ALU_OR;
                end
                OP_SLTI: begin
                    kind   = K_ALU;
                    useImm = 1'b1;
                    aluOp  = ALU_SLT;
                end
                OP_BEQ: begin
                    kind    = K_BRANCH;
                    brTaken = zero;
                end
                OP_BNE: begin
                    kind    = K_BRANCH;
                    brTaken = !zero;
                end
                OP_BLTZ: begin
                    kind    = K_BRANCH;
                    brTaken = sign;
                end
                OP_LW:   kind = K_LOAD;
                OP_SW:   kind = K_STORE;
                OP_J:    kind = K_J;
                OP_JAL:  kind = K_JAL;
                OP_HALT: kind = K_HALT;
                default: kind = K_ILLEGAL;
            endcase
        end
    end

    // Next-state and strobe generation; anything not driven in a state stays 0.
    always_comb begin
        nextState  = stateReg;
        PCWre      = 1'b0;
        IRWre      = 1'b0;
        InsMemRW   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 1'b0;
        DBDataSrc  = 1'b0;
        WrRegDSrc  = 1'b0;
        RegWre     = 1'b0;
        RegDst     = DST_RA;
        ExtSel     = 1'b0;
        mRD        = 1'b0;
        mWR        = 1'b0;
        ALUOp      = ALU_ADD;
        PCSrc      = PC_SEQ;
        illegal_op = 1'b0;
        halted     = 1'b0;
        case (stateReg)
            ST_IF: begin
                InsMemRW = 1'b1;
                if (imemOk) begin
                    IRWre     = 1'b1;
                    nextState = ST_ID;
                end
            end
            ST_ID: begin
                case (kind)
                    K_J: begin
                        PCWre     = 1'b1;
                        PCSrc     = PC_JUMP;
                        nextState = ST_IF;
                    end
                    K_JAL: begin
                        PCWre     = 1'b1;
                        PCSrc     = PC_JUMP;
                        RegWre    = 1'b1;
                        RegDst    = DST_RA;
                        WrRegDSrc = 1'b0;
                        nextState = ST_IF;
                    end
                    K_JR: begin
                        PCWre     = 1'b1;
                        PCSrc     = PC_RS;
                        nextState = ST_IF;
                    end
                    K_HALT:            nextState = ST_HALT;
                    K_ALU:             nextState = ST_EXE_AL;
                    K_BRANCH:          nextState = ST_EXE_BR;
                    K_LOAD, K_STORE:   nextState = ST_EXE_LS;
                    default: begin
                        // Undecodable word is skipped like a nop so the program keeps running.
                        illegal_op = 1'b1;
                        PCWre      = 1'b1;
                        PCSrc      = PC_SEQ;
                        nextState  = ST_IF;
                    end
                endcase
            end
            ST_EXE_AL: begin
                ALUSrcA   = useShamt;
                ALUSrcB   = useImm;
                ExtSel    = !zeroExt;
                ALUOp     = aluOp;
                nextState = ST_WB_AL;
            end
            ST_WB_AL: begin
                ALUSrcA   = useShamt;
                ALUSrcB   = useImm;
                ExtSel    = !zeroExt;
                ALUOp     = aluOp;
                RegWre    = 1'b1;
                RegDst    = rType ? DST_RD : DST_RT;
                WrRegDSrc = 1'b1;
                PCWre     = 1'b1;
                PCSrc     = PC_SEQ;
                nextState = ST_IF;
            end
            ST_EXE_BR: begin
                ALUOp     = ALU_SUB;
                ExtSel    = 1'b1;
                PCWre     = 1'b1;
                PCSrc     = brTaken ? PC_BRANCH : PC_SEQ;
                nextState = ST_IF;
            end
            ST_EXE_LS: begin
                ALUSrcB   = 1'b1;
                ExtSel    = 1'b1;
                ALUOp     = ALU_ADD;
                nextState = ST_MEM;
            end
            ST_MEM: begin
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                ALUOp   = ALU_ADD;
                mRD     = (kind == K_LOAD);
                mWR     = (kind == K_STORE);
                if (dmemOk) begin
                    if (kind == K_LOAD) begin
                        nextState = ST_WB_LD;
                    end else begin
                        PCWre     = 1'b1;
                        PCSrc     = PC_SEQ;
                        nextState = ST_IF;
                    end
                end
            end
            ST_WB_LD: begin
                RegWre    = 1'b1;
                RegDst    = DST_RT;
                DBDataSrc = 1'b1;
                WrRegDSrc = 1'b1;
                PCWre     = 1'b1;
                PCSrc     = PC_SEQ;
                nextState = ST_IF;
            end
            ST_HALT: halted = 1'b1;
            default: nextState = ST_IF;
        endcase
    end

    // Every PCWre pulse marks exactly one retired instruction.
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            stateReg    <= ST_IF;
            retired_cnt <= '0;
        end else begin
            stateReg <= nextState;
            if (PCWre) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

endmodule
